// File: rtl/intersection_phase_scheduler.sv
// rtl/intersection_phase_scheduler.sv - two-road intersection sequencer with pedestrian walk phase
// Latches EW and pedestrian requests and sequences both heads through green/yellow/all-red.
module intersection_phase_scheduler #(
  parameter int CNT_W       = 8,
  parameter int GREEN_MIN   = 4,
  parameter int GREEN_MAX   = 8,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ew_req,
  input  logic       ped_req,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR1  = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR2  = 3'd5,
    PED  = 3'd6
  } state_t;

  // Timer holds (cycles spent in state - 1), so "at T" compares against T-1.
  localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] T_Y    = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALLRED_TIME - 1);
  localparam logic [CNT_W-1:0] T_WALK = CNT_W'(WALK_TIME - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] timer;
  logic             ew_pend;
  logic             ped_pend;
  logic             from_ped;
  logic             from_ped_nx;

  // Lamp vector: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}
  function automatic logic [6:0] lamps(input state_t s);
    case (s)
      NS_G:    lamps = 7'b001_100_0;
      NS_Y:    lamps = 7'b010_100_0;
      EW_G:    lamps = 7'b100_001_0;
      EW_Y:    lamps = 7'b100_010_0;
      PED:     lamps = 7'b100_100_1;
      default: lamps = 7'b100_100_0;
    endcase
  endfunction

  always_comb begin
    state_nx    = state;
    from_ped_nx = from_ped;
    case (state)
      NS_G: if (timer >= T_GMIN && (ew_pend || ped_pend)) state_nx = NS_Y;
      NS_Y: if (timer >= T_Y) state_nx = AR1;
      AR1: begin
        if (timer >= T_AR) begin
          if (ped_pend)     state_nx = PED;
          else if (ew_pend) state_nx = EW_G;
          else              state_nx = NS_G;
        end
      end
      EW_G: if (timer >= T_GMAX || (timer >= T_GMIN && !ew_req)) state_nx = EW_Y;
      EW_Y: begin
        if (timer >= T_Y) begin
          state_nx    = AR2;
          from_ped_nx = 1'b0;
        end
      end
      PED: begin
        if (timer >= T_WALK) begin
          state_nx    = AR2;
          from_ped_nx = 1'b1;
        end
      end
      AR2: begin
        if (timer >= T_AR) begin
          state_nx    = (from_ped && ew_pend) ? EW_G : NS_G;
          from_ped_nx = 1'b0;
        end
      end
      default: state_nx = AR2;
    endcase
  end

  // Lamps are registered from the next state so they always mirror the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= AR2;
      timer     <= '0;
      ew_pend   <= 1'b0;
      ped_pend  <= 1'b0;
      from_ped  <= 1'b0;
      ns_red    <= 1'b1;
      ns_yellow <= 1'b0;
      ns_green  <= 1'b0;
      ew_red    <= 1'b1;
      ew_yellow <= 1'b0;
      ew_green  <= 1'b0;
      walk      <= 1'b0;
      phase     <= 3'd5;
    end else begin
      state    <= state_nx;
      from_ped <= from_ped_nx;
      if (state_nx != state)  timer <= '0;
      else if (timer != '1)   timer <= timer + 1'b1;
      // Clearing on entry wins over a same-cycle request.
      if (state_nx == PED && state != PED) ped_pend <= 1'b0;
      else if (ped_req)                    ped_pend <= 1'b1;
      if (state_nx == EW_G && state != EW_G) ew_pend <= 1'b0;
      else if (ew_req && state != EW_G)      ew_pend <= 1'b1;
      {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk} <= lamps(state_nx);
      phase <= state_nx;
    end
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb/tb_intersection_phase_scheduler.sv - self-checking bench for intersection_phase_scheduler
// Directed vector table, hand sequences and random traffic against a phase-level reference model.
module tb_intersection_phase_scheduler;

  localparam int GREEN_MIN   = 4;
  localparam int GREEN_MAX   = 8;
  localparam int YELLOW_TIME = 2;
  localparam int ALLRED_TIME = 1;
  localparam int WALK_TIME   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ew_req = 1'b0;
  logic       ped_req = 1'b0;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
  logic [2:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  intersection_phase_scheduler dut (
    .clk(clk), .reset(reset), .ew_req(ew_req), .ped_req(ped_req),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  // Reference model: phase number, cycles spent in it so far, request memory.
  int m_state, m_age;
  bit m_ew, m_ped, m_from;

  task automatic model_reset();
    m_state = 5; m_age = 1; m_ew = 0; m_ped = 0; m_from = 0;
  endtask

  task automatic model_step(input bit ew, input bit ped);
    int nx;
    bit from_nx;
    nx = m_state;
    from_nx = m_from;
    case (m_state)
      0: if (m_age >= GREEN_MIN && (m_ew || m_ped)) nx = 1;
      1: if (m_age >= YELLOW_TIME) nx = 2;
      2: if (m_age >= ALLRED_TIME) nx = m_ped ? 6 : (m_ew ? 3 : 0);
      3: if (m_age >= GREEN_MAX || (m_age >= GREEN_MIN && !ew)) nx = 4;
      4: if (m_age >= YELLOW_TIME) begin nx = 5; from_nx = 0; end
      6: if (m_age >= WALK_TIME) begin nx = 5; from_nx = 1; end
      5: if (m_age >= ALLRED_TIME) begin nx = (m_from && m_ew) ? 3 : 0; from_nx = 0; end
      default: nx = 5;
    endcase
    if (ped) m_ped = 1;
    if (ew && m_state != 3) m_ew = 1;
    if (nx == 6 && m_state != 6) m_ped = 0;
    if (nx == 3 && m_state != 3) m_ew = 0;
    m_age = (nx == m_state) ? m_age + 1 : 1;
    m_state = nx;
    m_from = from_nx;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_invariants();
    chk("ns_onehot", 32'($countones({ns_red, ns_yellow, ns_green})), 1);
    chk("ew_onehot", 32'($countones({ew_red, ew_yellow, ew_green})), 1);
    chk("heads_exclusive", 32'(!ns_red && !ew_red), 0);
    chk("walk_all_red", 32'(walk && !(ns_red && ew_red)), 0);
    chk("phase_legal", 32'(phase == 3'd7), 0);
  endtask

  task automatic check_model();
    logic [6:0] exp;
    exp = {!(m_state == 0 || m_state == 1), m_state == 1, m_state == 0,
           !(m_state == 3 || m_state == 4), m_state == 4, m_state == 3, m_state == 6};
    chk("phase", 32'(phase), 32'(m_state));
    chk("lamps", 32'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}), 32'(exp));
    check_invariants();
  endtask

  // Called at a falling edge; applies inputs across one rising edge and checks at the next fall.
  task automatic step(input bit ew, input bit ped);
    ew_req = ew;
    ped_req = ped;
    @(posedge clk);
    model_step(ew, ped);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    bit         ew;
    bit         ped;
    logic [2:0] ph;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit ew, input bit ped, input int ph, input int reps);
    vec_t v;
    v.ew = ew; v.ped = ped; v.ph = 3'(ph);
    for (int i = 0; i < reps; i++) tbl.push_back(v);
  endtask

  task automatic hold_reset_and_release();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_phase", 32'(phase), 5);
      chk("reset_lamps", 32'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}),
          32'(7'b100_100_0));
    end
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    int ewg_run, cnt, seen;
    bit ew_mode;
    model_reset();

    hold_reset_and_release();
    for (int i = 0; i < 50; i++) begin
      step(0, 0);
      if (i >= ALLRED_TIME) chk("idle_ns_green", 32'(ns_green), 1);
    end

    // Scenario 3: single EW pulse, EW_G held to GREEN_MIN
    add(1, 0, 0, 1); add(0, 0, 1, 2); add(0, 0, 2, 1); add(0, 0, 3, 4);
    add(0, 0, 4, 2); add(0, 0, 5, 1); add(0, 0, 0, 5);
    // Scenario 4: pedestrian only
    add(0, 1, 0, 1); add(0, 0, 1, 2); add(0, 0, 2, 1); add(0, 0, 6, 3);
    add(0, 0, 5, 1); add(0, 0, 0, 5);
    // Scenario 5: both together, PED first then EW via AR2
    add(1, 1, 0, 1); add(0, 0, 1, 2); add(0, 0, 2, 1); add(0, 0, 6, 3);
    add(0, 0, 5, 1); add(0, 0, 3, 4); add(0, 0, 4, 2); add(0, 0, 5, 1); add(0, 0, 0, 5);
    foreach (tbl[i]) begin
      step(tbl[i].ew, tbl[i].ped);
      chk("tbl_phase", 32'(phase), 32'(tbl[i].ph));
      chk("tbl_walk", 32'(walk), 32'(tbl[i].ph == 3'd6));
    end

    // Scenario 2: EW held -> EW_G capped at GREEN_MAX
    ewg_run = 0; seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      step(1, 0);
      if (phase == 3'd3) ewg_run++;
      else if (ewg_run != 0) seen = 1;
    end
    chk("ewg_cap", 32'(ewg_run), GREEN_MAX);
    for (int i = 0; i < 12; i++) step(0, 0);

    // Long idle saturates the timer; a later request must still be served.
    for (int i = 0; i < 300; i++) step(0, 0);
    cnt = 0;
    step(1, 0);
    while (phase != 3'd1 && cnt < 5) begin step(0, 0); cnt++; end
    chk("after_saturation_ns_y", 32'(phase), 1);
    for (int i = 0; i < 15; i++) step(0, 0);

    // Random traffic with occasional held EW demand
    ew_mode = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) ew_mode = !ew_mode;
      step(ew_mode ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0),
           $urandom_range(0, 24) == 0);
    end

    // Scenario 6: asynchronous reset in the middle of EW_G
    cnt = 0;
    while (m_state != 3 && cnt < 60) begin step(1, 0); cnt++; end
    chk("reached_ew_g", 32'(m_state), 3);
    step(1, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async_ns_red", 32'(ns_red), 1);
    chk("async_ew_red", 32'(ew_red), 1);
    chk("async_ew_green", 32'(ew_green), 0);
    chk("async_phase", 32'(phase), 5);
    ew_req = 1'b0;
    model_reset();
    hold_reset_and_release();
    for (int i = 0; i < 50; i++) begin
      step(0, 0);
      if (i >= ALLRED_TIME) chk("post_reset_ns_green", 32'(ns_green), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
